// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver, mid-bit sampling on the system clock.
// Ports: clk, rst (async, active-high), uart_rx (serial in, idle high),
//        data (last good byte), valid (1-cycle strobe),
//        frame_err (1-cycle strobe), busy (not idle).
module uart_rx_ctrl #(
    parameter int CLK_FREQ = 100000000,
    parameter int baud     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int BIT_TICKS  = CLK_FREQ / baud;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam logic [31:0] BIT_LAST  = 32'(BIT_TICKS - 1);
    localparam logic [31:0] HALF_LAST = 32'(HALF_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [31:0] timer, timer_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shreg, shreg_n;
    logic [7:0]  data_n;
    logic        valid_n, ferr_n;
    logic        rx_m, rx_s;

    // Synchroniser resets high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
        end
    end

    // The timer also restarts after every sample, so each data bit
    // gets a fresh full bit period measured from the previous centre.
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        data_n    = data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            S_IDLE: begin
                timer_n   = '0;
                bit_idx_n = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (timer == HALF_LAST) begin
                    timer_n = '0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end else begin
                    timer_n = timer + 32'd1;
                end
            end
            S_DATA: begin
                if (timer == BIT_LAST) begin
                    timer_n   = '0;
                    shreg_n   = {rx_s, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = S_STOP;
                end else begin
                    timer_n = timer + 32'd1;
                end
            end
            S_STOP: begin
                if (timer == BIT_LAST) begin
                    timer_n = '0;
                    if (rx_s) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end else begin
                    timer_n = timer + 32'd1;
                end
            end
            // Hold off until the line is released so a break is
            // not decoded as a run of zero bytes.
            S_BREAK: begin
                timer_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                state_n   = S_IDLE;
                timer_n   = '0;
                bit_idx_n = '0;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized self-checking bench for uart_rx_ctrl.
// Expected strobes come from a frame-level model: each frame sent maps
// to one valid/frame_err event at a fixed latency from its start edge.
module tb_uart_rx_ctrl;

    localparam int BIT  = 16;
    localparam int HALF = 8;
    localparam int LAT  = 2 + HALF + 9 * BIT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    typedef struct {
        int     kind;
        int     d;
        longint cyc;
    } ev_t;

    ev_t    exp_q[$];
    ev_t    obs_q[$];
    longint cyc = 0;
    int     overlap = 0;
    int     vecs = 0;
    int     errs = 0;
    int     last_good = 0;

    uart_rx_ctrl #(.CLK_FREQ(1600), .baud(100)) dut (
        .clk(clk),
        .rst(rst),
        .uart_rx(uart_rx),
        .data(data),
        .valid(valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) obs_q.push_back('{1, int'(data), cyc});
            if (frame_err) obs_q.push_back('{2, 0, cyc});
            if (valid && frame_err) overlap++;
        end
    end

    task automatic drive_bit(input logic b, input int n);
        uart_rx = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: a good frame yields a valid with its byte, a bad stop bit
    // yields a frame_err; both land LAT cycles after the start edge.
    task automatic send_frame(input logic [7:0] d, input logic stopb);
        if (stopb) begin
            exp_q.push_back('{1, int'(d), cyc + LAT});
            last_good = int'(d);
        end else begin
            exp_q.push_back('{2, 0, cyc + LAT});
        end
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
        drive_bit(stopb, BIT);
    endtask

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
        drive_bit(1'b1, 500);
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        vecs++;
        if (valid !== 1'b0 || frame_err !== 1'b0) begin
            errs++;
            $display("FAIL reset_strobes got %b%b want 00", valid, frame_err);
        end
        vecs++;
        if (data !== 8'h00) begin
            errs++;
            $display("FAIL reset_data got %h want 00", data);
        end
        vecs++;
        if (obs_q.size() != 0) begin
            errs++;
            $display("FAIL reset_events got %0d want 0", obs_q.size());
        end
    endtask

    task automatic test_single();
        longint diff;
        clear_q();
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, 40);
        vecs++;
        if (obs_q.size() != exp_q.size()) begin
            errs++;
            $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].d != exp_q[i].d) begin
                errs++;
                $display("FAIL single_ev%0d got k%0d %h want k%0d %h", i,
                         obs_q[i].kind, obs_q[i].d, exp_q[i].kind, exp_q[i].d);
            end
            diff = obs_q[i].cyc - exp_q[i].cyc;
            vecs++;
            if (diff > 2 || diff < -2) begin
                errs++;
                $display("FAIL single_lat%0d got %0d want %0d", i,
                         obs_q[i].cyc, exp_q[i].cyc);
            end
        end
        vecs++;
        if (int'(data) != last_good) begin
            errs++;
            $display("FAIL single_data got %h want %h", data, last_good);
        end
    endtask

    task automatic test_back_to_back();
        longint diff;
        clear_q();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        drive_bit(1'b1, 40);
        vecs++;
        if (obs_q.size() != exp_q.size()) begin
            errs++;
            $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].d != exp_q[i].d) begin
                errs++;
                $display("FAIL b2b_ev%0d got k%0d %h want k%0d %h", i,
                         obs_q[i].kind, obs_q[i].d, exp_q[i].kind, exp_q[i].d);
            end
            diff = obs_q[i].cyc - exp_q[i].cyc;
            vecs++;
            if (diff > 2 || diff < -2) begin
                errs++;
                $display("FAIL b2b_lat%0d got %0d want %0d", i,
                         obs_q[i].cyc, exp_q[i].cyc);
            end
        end
        vecs++;
        if (int'(data) != last_good) begin
            errs++;
            $display("FAIL b2b_data got %h want %h", data, last_good);
        end
    endtask

    task automatic test_frame_err();
        longint diff;
        clear_q();
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0, 40);
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL ferr_busy_low got %b want 1", busy);
        end
        vecs++;
        if (int'(data) != last_good) begin
            errs++;
            $display("FAIL ferr_data_held got %h want %h", data, last_good);
        end
        drive_bit(1'b1, 20);
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL ferr_busy_release got %b want 0", busy);
        end
        send_frame(8'h81, 1'b1);
        drive_bit(1'b1, 40);
        vecs++;
        if (obs_q.size() != exp_q.size()) begin
            errs++;
            $display("FAIL ferr_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].d != exp_q[i].d) begin
                errs++;
                $display("FAIL ferr_ev%0d got k%0d %h want k%0d %h", i,
                         obs_q[i].kind, obs_q[i].d, exp_q[i].kind, exp_q[i].d);
            end
            diff = obs_q[i].cyc - exp_q[i].cyc;
            vecs++;
            if (diff > 2 || diff < -2) begin
                errs++;
                $display("FAIL ferr_lat%0d got %0d want %0d", i,
                         obs_q[i].cyc, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_glitch();
        longint t0;
        int     n;
        clear_q();
        t0 = cyc;
        drive_bit(1'b0, 4);
        uart_rx = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        vecs++;
        if (cyc - t0 > HALF + 3) begin
            errs++;
            $display("FAIL glitch_busy_drop got %0d cycles want <= %0d",
                     cyc - t0, HALF + 3);
        end
        drive_bit(1'b1, 30);
        vecs++;
        if (obs_q.size() != 0) begin
            errs++;
            $display("FAIL glitch_events got %0d want 0", obs_q.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] c3;
        longint     diff;
        clear_q();
        c3 = 8'hC3;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 3; i++) drive_bit(c3[i], BIT);
        drive_bit(c3[3], BIT / 2);
        #2 rst = 1'b1;
        #1;
        last_good = 0;
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL mrst_busy got %b want 0", busy);
        end
        vecs++;
        if (data !== 8'h00) begin
            errs++;
            $display("FAIL mrst_data got %h want 00", data);
        end
        @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drive_bit(1'b1, 30);
        vecs++;
        if (obs_q.size() != 0) begin
            errs++;
            $display("FAIL mrst_events got %0d want 0", obs_q.size());
        end
        send_frame(8'h7E, 1'b1);
        drive_bit(1'b1, 40);
        vecs++;
        if (obs_q.size() != exp_q.size()) begin
            errs++;
            $display("FAIL mrst_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].d != exp_q[i].d) begin
                errs++;
                $display("FAIL mrst_ev%0d got k%0d %h want k%0d %h", i,
                         obs_q[i].kind, obs_q[i].d, exp_q[i].kind, exp_q[i].d);
            end
            diff = obs_q[i].cyc - exp_q[i].cyc;
            vecs++;
            if (diff > 2 || diff < -2) begin
                errs++;
                $display("FAIL mrst_lat%0d got %0d want %0d", i,
                         obs_q[i].cyc, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_random();
        longint diff;
        clear_q();
        for (int f = 0; f < 20; f++) begin
            send_frame(8'($urandom), 1'b1);
            drive_bit(1'b1, $urandom_range(0, 20));
        end
        drive_bit(1'b1, 40);
        vecs++;
        if (obs_q.size() != exp_q.size()) begin
            errs++;
            $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].d != exp_q[i].d) begin
                errs++;
                $display("FAIL rand_ev%0d got k%0d %h want k%0d %h", i,
                         obs_q[i].kind, obs_q[i].d, exp_q[i].kind, exp_q[i].d);
            end
            diff = obs_q[i].cyc - exp_q[i].cyc;
            vecs++;
            if (diff > 2 || diff < -2) begin
                errs++;
                $display("FAIL rand_lat%0d got %0d want %0d", i,
                         obs_q[i].cyc, exp_q[i].cyc);
            end
        end
        vecs++;
        if (int'(data) != last_good) begin
            errs++;
            $display("FAIL rand_data got %h want %h", data, last_good);
        end
        vecs++;
        if (overlap != 0) begin
            errs++;
            $display("FAIL strobe_overlap got %0d want 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
